a_addn_serial: RTL and testbench

- Parametrised successor to the one-bit bundled-data adder stage.
- Adds two W-bit operands plus a carry-in token, CHUNK bits per clock, on a single clock.
- Uses the codebase's two-phase r/a/d channel convention on all four channels: operand, carry-in, sum and carry-out.
- Sits in arith/ between flow/ and active/ stages. Allows wide adds without a W-bit carry chain per cycle.

---
 rtl/a_arith_pkg.sv | 20 ++
 rtl/a_add_slice.sv | 15 +
 rtl/a_addn_serial.sv | 126 ++++++++++++
 tb/tb_a_addn_serial.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/a_arith_pkg.sv
// Shared types and helpers for the arith/ stages: FSM states, two-phase token
// detection and counter sizing.
package a_arith_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COMPUTE,
    EMIT
  } state_t;

  // A two-phase token is pending whenever request and acknowledge disagree.
  function automatic logic pending(input logic r, input logic a);
    return r != a;
  endfunction

  function automatic int nchWidth(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/a_add_slice.sv
// Combinational CHUNK-bit ripple slice; the serial adder reuses one copy every
// cycle.
module a_add_slice #(
  parameter int CHUNK = 2
) (
  input  logic [CHUNK-1:0] i_a,
  input  logic [CHUNK-1:0] i_b,
  input  logic             i_cin,
  output logic [CHUNK-1:0] o_sum,
  output logic             o_cout
);

  assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {{CHUNK{1'b0}}, i_cin};

endmodule

// File: rtl/a_addn_serial.sv
// Chunk-serial W-bit adder with two-phase operand, carry-in, sum and
// carry-out channels; one CHUNK-bit slice is reused for NCH cycles per add.
module a_addn_serial
  import a_arith_pkg::*;
#(
  parameter logic Rpol  = 1'b0,
  parameter int   W     = 8,
  parameter int   CHUNK = 2,
  parameter logic SUB   = 1'b0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           r_i,
  output logic           a_i,
  input  logic [2*W-1:0] d_i,
  input  logic           rc_i,
  output logic           ac_i,
  input  logic           dc_i,
  output logic           r_o,
  input  logic           a_o,
  output logic [W-1:0]   d_o,
  output logic           rc_o,
  input  logic           ac_o,
  output logic           dc_o,
  output logic           err
);

  localparam int NCH = W / CHUNK;
  localparam int KW = nchWidth(NCH);
  localparam logic [KW-1:0] LAST = KW'(NCH - 1);

  state_t          r_state;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [W-1:0]    r_sum;
  logic            r_carry;
  logic [KW-1:0]   r_k;
  logic            r_riPrev;
  logic            r_rciPrev;
  logic            r_aoPrev;
  logic            r_acoPrev;

  logic [CHUNK-1:0] w_chunkSum;
  logic             w_chunkCout;
  logic [W-1:0]     w_sumNext;
  logic             w_protoErr;

  a_add_slice #(.CHUNK(CHUNK)) u_slice (
    .i_a   (r_a[CHUNK-1:0]),
    .i_b   (r_b[CHUNK-1:0]),
    .i_cin (r_carry),
    .o_sum (w_chunkSum),
    .o_cout(w_chunkCout)
  );

  // Operands shift right each cycle; the new chunk enters the sum from the top,
  // so after NCH cycles the sum register holds the result in place.
  assign w_sumNext = W'({w_chunkSum, r_sum} >> CHUNK);

  assign w_protoErr = ((a_o  != r_aoPrev)  && (r_aoPrev  == r_o))
                   || ((ac_o != r_acoPrev) && (r_acoPrev == rc_o))
                   || ((r_i  != r_riPrev)  && pending(r_riPrev, a_i))
                   || ((rc_i != r_rciPrev) && pending(r_rciPrev, ac_i));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_a       <= '0;
      r_b       <= '0;
      r_sum     <= '0;
      r_carry   <= 1'b0;
      r_k       <= '0;
      r_riPrev  <= Rpol;
      r_rciPrev <= Rpol;
      r_aoPrev  <= Rpol;
      r_acoPrev <= Rpol;
      a_i       <= Rpol;
      ac_i      <= Rpol;
      r_o       <= Rpol;
      rc_o      <= Rpol;
      d_o       <= '0;
      dc_o      <= 1'b0;
      err       <= 1'b0;
    end else begin
      r_riPrev  <= r_i;
      r_rciPrev <= rc_i;
      r_aoPrev  <= a_o;
      r_acoPrev <= ac_o;
      if (w_protoErr) err <= 1'b1;

      case (r_state)
        IDLE: begin
          if (pending(r_i, a_i) && pending(rc_i, ac_i)) begin
            r_a     <= d_i[2*W-1:W];
            r_b     <= SUB ? ~d_i[W-1:0] : d_i[W-1:0];
            r_carry <= dc_i;
            r_sum   <= '0;
            r_k     <= '0;
            a_i     <= ~a_i;
            ac_i    <= ~ac_i;
            r_state <= COMPUTE;
          end
        end
        COMPUTE: begin
          r_a     <= r_a >> CHUNK;
          r_b     <= r_b >> CHUNK;
          r_sum   <= w_sumNext;
          r_carry <= w_chunkCout;
          r_k     <= r_k + 1'b1;
          if (r_k == LAST) begin
            d_o     <= w_sumNext;
            dc_o    <= w_chunkCout;
            r_o     <= ~r_o;
            rc_o    <= ~rc_o;
            r_state <= EMIT;
          end
        end
        EMIT: begin
          if ((a_o == r_o) && (ac_o == rc_o)) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_a_addn_serial.sv
// Scoreboard bench for a_addn_serial: an add (SUB=0) and a subtract (SUB=1)
// instance share every input; a monitor pops expected results on each r_o toggle.
module tb_a_addn_serial;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        r_i, rc_i, dc_i, a_o, ac_o;
  logic [15:0] d_i;

  logic       a_i0, ac_i0, r_o0, rc_o0, dc_o0, err0;
  logic [7:0] d_o0;
  logic       a_i1, ac_i1, r_o1, rc_o1, dc_o1, err1;
  logic [7:0] d_o1;

  typedef struct packed {
    logic [7:0] sum;
    logic       c;
  } exp_t;

  exp_t addQ[$];
  exp_t subQ[$];
  int   total = 0;
  int   bad   = 0;

  logic prevRo0 = 1'b0, prevRc0 = 1'b0, prevRo1 = 1'b0, prevRc1 = 1'b0;

  always #5 clk = ~clk;

  a_addn_serial #(.Rpol(1'b0), .W(8), .CHUNK(2), .SUB(1'b0)) dutAdd (
    .clk(clk), .rst(rst_n),
    .r_i(r_i), .a_i(a_i0), .d_i(d_i),
    .rc_i(rc_i), .ac_i(ac_i0), .dc_i(dc_i),
    .r_o(r_o0), .a_o(a_o), .d_o(d_o0),
    .rc_o(rc_o0), .ac_o(ac_o), .dc_o(dc_o0),
    .err(err0)
  );

  a_addn_serial #(.Rpol(1'b0), .W(8), .CHUNK(2), .SUB(1'b1)) dutSub (
    .clk(clk), .rst(rst_n),
    .r_i(r_i), .a_i(a_i1), .d_i(d_i),
    .rc_i(rc_i), .ac_i(ac_i1), .dc_i(dc_i),
    .r_o(r_o1), .a_o(a_o), .d_o(d_o1),
    .rc_o(rc_o1), .ac_o(ac_o), .dc_o(dc_o1),
    .err(err1)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic cin,
                               input logic [7:0] addS, input logic addC,
                               input logic [7:0] subS, input logic subC);
    @(negedge clk);
    d_i  = {a, b};
    dc_i = cin;
    r_i  = ~r_i;
    rc_i = ~rc_i;
    addQ.push_back('{addS, addC});
    subQ.push_back('{subS, subC});
  endtask

  task automatic waitAccept(output int cycles);
    cycles = 0;
    do begin
      @(posedge clk);
      #1;
      cycles++;
    end while ((a_i0 != r_i || ac_i0 != rc_i) && cycles < 30);
  endtask

  task automatic waitEmit(output int cycles);
    cycles = 0;
    do begin
      @(posedge clk);
      #1;
      cycles++;
    end while (r_o0 == a_o && cycles < 30);
  endtask

  task automatic ackBoth();
    @(negedge clk);
    a_o  = r_o0;
    ac_o = rc_o0;
  endtask

  task automatic runTxn(input logic [7:0] a, input logic [7:0] b, input logic cin,
                        input logic [7:0] addS, input logic addC,
                        input logic [7:0] subS, input logic subC);
    int n;
    applyStimulus(a, b, cin, addS, addC, subS, subC);
    waitAccept(n);
    checkOutput("accept_latency", n, 1);
    waitEmit(n);
    checkOutput("emit_latency", n, 4);
    ackBoth();
  endtask

  // Monitor: every r_o toggle out of reset is one result to retire.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && r_o0 !== prevRo0) begin
        checkOutput("rc_o_pair_add", rc_o0 ^ prevRc0, 1);
        if (addQ.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_add_output: got 0x%0h expected none", d_o0);
        end else begin
          e = addQ.pop_front();
          checkOutput("add_sum", d_o0, e.sum);
          checkOutput("add_carry", dc_o0, e.c);
        end
      end
      if (rst_n && r_o1 !== prevRo1) begin
        checkOutput("rc_o_pair_sub", rc_o1 ^ prevRc1, 1);
        if (subQ.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_sub_output: got 0x%0h expected none", d_o1);
        end else begin
          e = subQ.pop_front();
          checkOutput("sub_sum", d_o1, e.sum);
          checkOutput("sub_carry", dc_o1, e.c);
        end
      end
      prevRo0 = r_o0;
      prevRc0 = rc_o0;
      prevRo1 = r_o1;
      prevRc1 = rc_o1;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int moves;
    rst_n = 1'b0;
    r_i = 1'b0; rc_i = 1'b0; dc_i = 1'b0; a_o = 1'b0; ac_o = 1'b0; d_i = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_ctrl_add", {a_i0, ac_i0, r_o0, rc_o0, dc_o0, err0}, 0);
    checkOutput("reset_d_o_add", d_o0, 0);
    checkOutput("reset_ctrl_sub", {a_i1, ac_i1, r_o1, rc_o1, dc_o1, err1}, 0);
    rst_n = 1'b1;

    runTxn(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 8'h1D, 1'b1);
    runTxn(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 8'hFD, 1'b1);
    runTxn(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 8'h00, 1'b1);
    runTxn(8'h10, 8'h20, 1'b1, 8'h31, 1'b0, 8'hF0, 1'b0);
    runTxn(8'h20, 8'h10, 1'b1, 8'h31, 1'b0, 8'h10, 1'b1);

    // Operand token alone must wait for its carry partner.
    @(negedge clk);
    d_i  = {8'h12, 8'h34};
    dc_i = 1'b0;
    r_i  = ~r_i;
    moves = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (a_i0 == r_i) moves++;
    end
    checkOutput("lone_token_held", moves, 0);
    @(negedge clk);
    rc_i = ~rc_i;
    addQ.push_back('{8'h46, 1'b0});
    subQ.push_back('{8'hDD, 1'b0});
    waitAccept(n);
    checkOutput("lone_token_accept", n, 1);
    waitEmit(n);
    checkOutput("lone_token_emit", n, 4);
    ackBoth();
    checkOutput("no_err_after_lone", err0, 0);

    // Sum ack three cycles ahead of carry ack, next token already waiting.
    applyStimulus(8'hA1, 8'h0F, 1'b1, 8'hB1, 1'b0, 8'h92, 1'b1);
    waitAccept(n);
    checkOutput("split_ack_accept", n, 1);
    waitEmit(n);
    checkOutput("split_ack_emit", n, 4);
    applyStimulus(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 8'hFE, 1'b0);
    a_o = r_o0;
    moves = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (a_i0 == r_i) moves++;
    end
    checkOutput("held_in_emit", moves, 0);
    @(negedge clk);
    ac_o = rc_o0;
    waitAccept(n);
    checkOutput("accept_after_split_ack", n, 2);
    waitEmit(n);
    checkOutput("emit_after_split_ack", n, 4);
    ackBoth();

    // Both acks in the same cycle, next token already waiting.
    applyStimulus(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 8'hFF, 1'b0);
    waitAccept(n);
    checkOutput("joint_ack_accept", n, 1);
    waitEmit(n);
    checkOutput("joint_ack_emit", n, 4);
    applyStimulus(8'h7F, 8'h01, 1'b1, 8'h81, 1'b0, 8'h7E, 1'b1);
    a_o  = r_o0;
    ac_o = rc_o0;
    waitAccept(n);
    checkOutput("accept_after_joint_ack", n, 2);
    waitEmit(n);
    checkOutput("emit_after_joint_ack", n, 4);
    ackBoth();

    // Reset in the middle of COMPUTE discards the token in flight.
    @(negedge clk);
    d_i  = {8'h33, 8'h44};
    dc_i = 1'b0;
    r_i  = ~r_i;
    rc_i = ~rc_i;
    waitAccept(n);
    checkOutput("abort_accept", n, 1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("abort_ctrl_add", {a_i0, ac_i0, r_o0, rc_o0, dc_o0, err0}, 0);
    checkOutput("abort_d_o_add", d_o0, 0);
    checkOutput("abort_d_o_sub", d_o1, 0);
    r_i = 1'b0; rc_i = 1'b0; a_o = 1'b0; ac_o = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    moves = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (r_o0 !== 1'b0 || rc_o0 !== 1'b0) moves++;
    end
    checkOutput("no_emit_after_abort", moves, 0);

    // Spurious ack with nothing outstanding sets the sticky error.
    @(negedge clk);
    a_o = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("err_set_add", err0, 1);
    checkOutput("err_set_sub", err1, 1);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("err_sticky", err0, 1);
    @(negedge clk);
    a_o   = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("err_cleared", err0, 0);
    rst_n = 1'b1;

    runTxn(8'h0F, 8'hF1, 1'b0, 8'h00, 1'b1, 8'h1D, 1'b0);
    repeat (3) @(negedge clk);
    checkOutput("add_queue_empty", addQ.size(), 0);
    checkOutput("sub_queue_empty", subQ.size(), 0);
    checkOutput("final_err", {err0, err1}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
